// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 VGA timing constants shared by sync and sprite stages
package vga_timing_pkg;

   localparam int POS_W = 10;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Inclusive unsigned window test on a raster coordinate.
   function automatic logic in_window(input logic [POS_W-1:0] pos,
                                      input logic [POS_W-1:0] lo,
                                      input logic [POS_W-1:0] hi);
      return (pos >= lo) && (pos <= hi);
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - raster timing bundle from the sync generator to pixel stages (o_frame_cnt with VGA_FRAME_CNT_EN)
interface vga_sync_gen_if;
   import vga_timing_pkg::*;

   logic             o_pix_stb;
   logic [POS_W-1:0] xx;
   logic [POS_W-1:0] yy;
   logic             aactive;
   logic             o_hsync;
   logic             o_vsync;
   logic             o_line_end;
   logic             o_frame_end;
`ifdef VGA_FRAME_CNT_EN
   logic [7:0]       o_frame_cnt;
`endif

   modport master (
      output o_pix_stb, xx, yy, aactive, o_hsync, o_vsync, o_line_end, o_frame_end
`ifdef VGA_FRAME_CNT_EN
      , output o_frame_cnt
`endif
   );

   modport slave (
      input o_pix_stb, xx, yy, aactive, o_hsync, o_vsync, o_line_end, o_frame_end
`ifdef VGA_FRAME_CNT_EN
      , input o_frame_cnt
`endif
   );

endinterface

// File: rtl/pixel_strobe_gen.sv
// rtl/pixel_strobe_gen.sv - one-cycle enable every CLK_DIV clocks (pixel-rate strobe)
module pixel_strobe_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_stb
);

   localparam int             DIV_W    = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign o_stb = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster/sync generator; VGA_FRAME_CNT_EN adds an 8-bit frame counter
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
   parameter int H_FP     = vga_timing_pkg::H_FP,
   parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
   parameter int H_BP     = vga_timing_pkg::H_BP,
   parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
   parameter int V_FP     = vga_timing_pkg::V_FP,
   parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
   parameter int V_BP     = vga_timing_pkg::V_BP,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   vga_sync_gen_if.master vid
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOT > 1023 || V_TOT > 1023) begin : g_bad_totals
      $error("vga_sync_gen: timing totals exceed the 10-bit position range");
   end
   if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_sync_gen: CLK_DIV outside 2..16");
   end

   localparam logic [POS_W-1:0] H_LAST     = POS_W'(H_TOT - 1);
   localparam logic [POS_W-1:0] V_LAST     = POS_W'(V_TOT - 1);
   localparam logic [POS_W-1:0] H_ACT      = POS_W'(H_ACTIVE);
   localparam logic [POS_W-1:0] V_ACT      = POS_W'(V_ACTIVE);
   localparam logic [POS_W-1:0] H_ACT_LAST = POS_W'(H_ACTIVE - 1);
   localparam logic [POS_W-1:0] V_ACT_LAST = POS_W'(V_ACTIVE - 1);
   localparam logic [POS_W-1:0] HS_LO      = POS_W'(H_ACTIVE + H_FP);
   localparam logic [POS_W-1:0] HS_HI      = POS_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [POS_W-1:0] VS_LO      = POS_W'(V_ACTIVE + V_FP);
   localparam logic [POS_W-1:0] VS_HI      = POS_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic             stb;
   logic [POS_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
   logic             act_nxt, le_nxt, fe_nxt;

   pixel_strobe_gen #(.CLK_DIV(CLK_DIV)) u_pix_stb (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .o_stb   (stb)
   );

   // Outputs are decoded from the position the counters are about to take,
   // so the registered outputs and the counters land on the same edge.
   always_comb begin
      h_nxt = h_cnt + 1'b1;
      v_nxt = v_cnt;
      if (h_cnt == H_LAST) begin
         h_nxt = '0;
         v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end
   end

   assign act_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
   assign le_nxt  = (h_nxt == H_ACT_LAST) && (v_nxt < V_ACT);
   assign fe_nxt  = le_nxt && (v_nxt == V_ACT_LAST);

   // Counters start at the last position so the first strobe lands on (0,0).
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         h_cnt           <= H_LAST;
         v_cnt           <= V_LAST;
         vid.o_pix_stb   <= 1'b0;
         vid.xx          <= '0;
         vid.yy          <= '0;
         vid.aactive     <= 1'b0;
         vid.o_hsync     <= ~SYNC_POL;
         vid.o_vsync     <= ~SYNC_POL;
         vid.o_line_end  <= 1'b0;
         vid.o_frame_end <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
         vid.o_frame_cnt <= '0;
`endif
      end else begin
         vid.o_pix_stb   <= stb;
         vid.o_line_end  <= stb && le_nxt;
         vid.o_frame_end <= stb && fe_nxt;
         if (stb) begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            vid.xx      <= h_nxt;
            vid.yy      <= v_nxt;
            vid.aactive <= act_nxt;
            vid.o_hsync <= in_window(h_nxt, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
            vid.o_vsync <= in_window(v_nxt, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
`ifdef VGA_FRAME_CNT_EN
            if (fe_nxt) begin
               vid.o_frame_cnt <= vid.o_frame_cnt + 1'b1;
            end
`endif
         end
      end
   end

endmodule
